// File: rtl/writeback_unit_m00_axis_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit_m00_axis_if
// Purpose  : AXI-Stream bus bundle between the result writeback unit and the
//            outbound DMA channel (M00_AXIS).
// Signals  : M_AXIS_TVALID  master -> slave  beat valid
//            M_AXIS_TDATA   master -> slave  beat data
//            M_AXIS_TSTRB   master -> slave  byte strobes
//            M_AXIS_TLAST   master -> slave  final beat of the block
//            M_AXIS_TREADY  slave  -> master downstream ready
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_unit_m00_axis_if #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32
);
  logic                                M_AXIS_TVALID;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA;
  logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB;
  logic                                M_AXIS_TLAST;
  logic                                M_AXIS_TREADY;

  modport master (
    output M_AXIS_TVALID,
    output M_AXIS_TDATA,
    output M_AXIS_TSTRB,
    output M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TVALID,
    input  M_AXIS_TDATA,
    input  M_AXIS_TSTRB,
    input  M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface
`default_nettype wire

// File: rtl/writeback_unit_m00_axis.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit_m00_axis
// Purpose  : Streams a block of result words out of the result BRAM onto an
//            AXI-Stream master. A start pulse latches a word count; the unit
//            reads addresses 0..count-1, hides the 1-cycle BRAM latency in a
//            2-entry buffer and sends one beat per cycle when the sink is
//            ready, with TLAST on the final word.
// Ports    : M_AXIS_ACLK     clock, rising edge
//            M_AXIS_ARESETN  asynchronous active-low reset
//            start           1-cycle transfer request (ignored while busy)
//            word_count      words to send, 0..2**BRAM_DEPTH, latched on start
//            busy            transfer in progress
//            done            1-cycle completion pulse
//            res_addr        result BRAM read address
//            res_en          result BRAM read enable
//            res_dout        result BRAM read data, valid 1 cycle after res_en
//            m_axis          AXI-Stream master bundle
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit_m00_axis #(
  parameter int BRAM_DEPTH           = 10,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  wire                            M_AXIS_ACLK,
  input  wire                            M_AXIS_ARESETN,
  input  wire                            start,
  input  wire [BRAM_DEPTH:0]             word_count,
  output logic                           busy,
  output logic                           done,
  output logic [BRAM_DEPTH-1:0]          res_addr,
  output logic                           res_en,
  input  wire [C_M_AXIS_TDATA_WIDTH-1:0] res_dout,
  writeback_unit_m00_axis_if.master      m_axis
);

  localparam int                c_strb_w = C_M_AXIS_TDATA_WIDTH / 8;
  localparam logic [BRAM_DEPTH:0] c_one  = {{BRAM_DEPTH{1'b0}}, 1'b1};
  localparam logic [BRAM_DEPTH:0] c_zero = '0;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                          r_state;
  logic [BRAM_DEPTH:0]             r_count;     // latched word count
  logic [BRAM_DEPTH:0]             r_rd_cnt;    // reads issued so far
  logic [BRAM_DEPTH:0]             r_beat_cnt;  // index of the head beat
  logic                            r_in_flight; // read issued last cycle, data arrives now
  logic [1:0]                      r_occ;       // buffer occupancy 0..2
  logic [C_M_AXIS_TDATA_WIDTH-1:0] r_tdata;     // buffer head, drives TDATA directly
  logic [C_M_AXIS_TDATA_WIDTH-1:0] r_spare;     // second buffer entry
  logic                            r_tvalid;
  logic                            r_done;

  logic w_pop;
  logic w_push;
  logic w_last_beat;
  logic w_room;
  logic w_issue;

  assign w_pop       = r_tvalid & m_axis.M_AXIS_TREADY;
  assign w_push      = r_in_flight;
  assign w_last_beat = (r_beat_cnt == (r_count - c_one));

  // A new read may go out only if, after this cycle's pop, the buffer can
  // still hold everything already in flight plus the new word.
  assign w_room  = ({1'b0, r_occ} + {2'b00, r_in_flight}) < (3'd2 + {2'b00, w_pop});
  assign w_issue = (r_state == ST_STREAM) && (r_rd_cnt < r_count) && w_room;

  // The read request is presented in the same cycle it is decided so that the
  // first address leaves one cycle after start and a full-rate stream needs
  // only two buffer entries. It is derived purely from registers plus TREADY.
  assign res_en   = w_issue;
  assign res_addr = r_rd_cnt[BRAM_DEPTH-1:0];

  assign busy                 = (r_state == ST_STREAM);
  assign done                 = r_done;
  assign m_axis.M_AXIS_TVALID = r_tvalid;
  assign m_axis.M_AXIS_TDATA  = r_tdata;
  assign m_axis.M_AXIS_TSTRB  = {c_strb_w{r_tvalid}};
  assign m_axis.M_AXIS_TLAST  = r_tvalid & w_last_beat;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_rd_cnt    <= '0;
      r_beat_cnt  <= '0;
      r_in_flight <= 1'b0;
      r_occ       <= 2'd0;
      r_tdata     <= '0;
      r_spare     <= '0;
      r_tvalid    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_in_flight <= w_issue;

      if (w_issue) begin
        r_rd_cnt <= r_rd_cnt + c_one;
      end

      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + c_one;
      end

      // Two-entry FIFO: r_tdata is the head, r_spare the tail. Push without
      // pop at occupancy 2 cannot occur because reads are throttled above.
      case (r_occ)
        2'd0: begin
          if (w_push) begin
            r_tdata  <= res_dout;
            r_tvalid <= 1'b1;
            r_occ    <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_tdata <= res_dout;
          end else if (w_push) begin
            r_spare <= res_dout;
            r_occ   <= 2'd2;
          end else if (w_pop) begin
            r_tvalid <= 1'b0;
            r_occ    <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_tdata <= r_spare;
            if (w_push) begin
              r_spare <= res_dout;
            end else begin
              r_occ <= 2'd1;
            end
          end
        end
      endcase

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count    <= word_count;
            r_rd_cnt   <= '0;
            r_beat_cnt <= '0;
            if (word_count == c_zero) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_pop && w_last_beat) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit_m00_axis.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit_m00_axis
// Purpose  : Self-checking bench for writeback_unit_m00_axis. A behavioural
//            BRAM holds i+1 at address i; expected beats are queued when a
//            transfer is started and compared as handshakes occur.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_unit_m00_axis;

  localparam int BD = 10;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [BD:0]   word_count;
  logic          busy;
  logic          done;
  logic [BD-1:0] res_addr;
  logic          res_en;
  logic [W-1:0]  res_dout;

  writeback_unit_m00_axis_if #(.C_M_AXIS_TDATA_WIDTH(W)) axis ();

  writeback_unit_m00_axis #(
    .BRAM_DEPTH          (BD),
    .C_M_AXIS_TDATA_WIDTH(W)
  ) dut (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESETN(rst_n),
    .start         (start),
    .word_count    (word_count),
    .busy          (busy),
    .done          (done),
    .res_addr      (res_addr),
    .res_en        (res_en),
    .res_dout      (res_dout),
    .m_axis        (axis)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:(1<<BD)-1];

  always @(posedge clk) begin
    if (res_en) res_dout <= mem[res_addr];
  end

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t sb_q[$];

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            beats, done_cnt, tvalid_cnt, rden_cnt;
  int            first_beat_cyc, last_beat_cyc;
  logic [BD-1:0] last_addr;
  logic          ready_random;
  logic          prev_stall;
  logic [W-1:0]  prev_data;
  logic          prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    beats      = 0;
    done_cnt   = 0;
    tvalid_cnt = 0;
    rden_cnt   = 0;
    prev_stall = 1'b0;
    first_beat_cyc = 0;
    last_beat_cyc  = 0;
  endtask

  // One clock cycle: observe at the falling edge, return 1 time unit after
  // the next rising edge so the caller can drive inputs.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (rst_n) begin
      if (axis.M_AXIS_TVALID) tvalid_cnt++;
      if (res_en) begin
        rden_cnt++;
        last_addr = res_addr;
      end
      if (done) begin
        done_cnt++;
        check("busy_low_with_done", busy, 1'b0);
      end
      if (axis.M_AXIS_TVALID || prev_stall)
        check("tstrb", axis.M_AXIS_TSTRB, {(W/8){axis.M_AXIS_TVALID}});
      if (prev_stall) begin
        check("stall_tvalid", axis.M_AXIS_TVALID, 1'b1);
        check("stall_tdata", axis.M_AXIS_TDATA, prev_data);
        check("stall_tlast", axis.M_AXIS_TLAST, prev_last);
      end
      if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
        if (beats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beats++;
        check("sb_nonempty", (sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
          b = sb_q.pop_front();
          check("beat_tdata", axis.M_AXIS_TDATA, b.data);
          check("beat_tlast", axis.M_AXIS_TLAST, b.last);
        end
      end
      prev_stall = axis.M_AXIS_TVALID && !axis.M_AXIS_TREADY;
      prev_data  = axis.M_AXIS_TDATA;
      prev_last  = axis.M_AXIS_TLAST;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (ready_random) axis.M_AXIS_TREADY = 1'($urandom_range(0, 1));
  endtask

  task automatic start_xfer(input int n, input bit push);
    word_count = (BD+1)'(n);
    start      = 1'b1;
    if (push) begin
      for (int i = 0; i < n; i++) sb_q.push_back('{data: mem[i], last: (i == n-1)});
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0 = done_cnt;
    int k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, (done_cnt != d0), 1'b1);
    check({tag, "_busy_after_done"}, busy, 1'b0);
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < (1<<BD); i++) mem[i] = W'(i + 1);
    rst_n = 1'b0;
    start = 1'b0;
    word_count = '0;
    axis.M_AXIS_TREADY = 1'b0;
    ready_random = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_tvalid", axis.M_AXIS_TVALID, 1'b0);
    check("rst_tlast", axis.M_AXIS_TLAST, 1'b0);
    check("rst_tdata", axis.M_AXIS_TDATA, '0);
    check("rst_tstrb", axis.M_AXIS_TSTRB, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res_en", res_en, 1'b0);
    check("rst_res_addr", res_addr, '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: 16 words at full rate, latency start -> res_en -> TVALID
    clear_stats();
    axis.M_AXIS_TREADY = 1'b1;
    start_xfer(16, 1'b1);
    check("t1_res_en_k1", res_en, 1'b1);
    check("t1_res_addr_k1", res_addr, '0);
    check("t1_busy", busy, 1'b1);
    check("t1_tvalid_k1", axis.M_AXIS_TVALID, 1'b0);
    tick();
    check("t1_tvalid_k2", axis.M_AXIS_TVALID, 1'b0);
    tick();
    check("t1_tvalid_k3", axis.M_AXIS_TVALID, 1'b1);
    check("t1_tdata_k3", axis.M_AXIS_TDATA, 32'd1);
    wait_done(100, "t1");
    check("t1_beats", beats, 16);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_span", last_beat_cyc - first_beat_cyc, 15);
    check("t1_sb_empty", sb_q.size(), 0);

    // 2: random backpressure
    clear_stats();
    ready_random = 1'b1;
    start_xfer(16, 1'b1);
    wait_done(400, "t2");
    ready_random = 1'b0;
    axis.M_AXIS_TREADY = 1'b1;
    check("t2_beats", beats, 16);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_sb_empty", sb_q.size(), 0);

    // 3a: single word
    clear_stats();
    start_xfer(1, 1'b1);
    wait_done(50, "t3a");
    check("t3a_beats", beats, 1);
    check("t3a_done_cnt", done_cnt, 1);

    // 3b: zero words
    clear_stats();
    start_xfer(0, 1'b0);
    wait_done(20, "t3b");
    check("t3b_tvalid_cnt", tvalid_cnt, 0);
    check("t3b_rden_cnt", rden_cnt, 0);
    check("t3b_done_cnt", done_cnt, 1);

    // 4: reset after beat 5, then a fresh 4-word transfer
    clear_stats();
    start_xfer(16, 1'b1);
    for (int k = 0; k < 100 && beats < 5; k++) tick();
    check("t4_reached_beat5", beats, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_tvalid", axis.M_AXIS_TVALID, 1'b0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_res_en", res_en, 1'b0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
    clear_stats();
    start_xfer(4, 1'b1);
    check("t4_restart_addr", res_addr, '0);
    check("t4_restart_en", res_en, 1'b1);
    wait_done(50, "t4");
    check("t4_beats", beats, 4);
    check("t4_sb_empty", sb_q.size(), 0);

    // 5: start re-pulsed mid-stream is ignored
    clear_stats();
    start_xfer(16, 1'b1);
    repeat (6) tick();
    word_count = 11'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_kept", busy, 1'b1);
    wait_done(100, "t5");
    check("t5_beats", beats, 16);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_sb_empty", sb_q.size(), 0);

    // 6: full BRAM, no wrap
    clear_stats();
    start_xfer(1 << BD, 1'b1);
    wait_done(1200, "t6");
    check("t6_beats", beats, 1 << BD);
    check("t6_last_addr", last_addr, {BD{1'b1}});
    check("t6_rden_cnt", rden_cnt, 1 << BD);
    check("t6_span", last_beat_cyc - first_beat_cyc, (1 << BD) - 1);
    check("t6_done_cnt", done_cnt, 1);
    check("t6_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
